axis_sample_packer: RTL and testbench

Single-clock AXI-stream width packer that sits directly upstream of the async FIFO clock converter in the sample path. It collects RATIO narrow sample beats into one wide beat, lane 0 in the LSBs. A partial word can be flushed early, zero-padded, on `s_axis_tlast`. The output is a single registered stage whose width matches the FIFO write width (default 4×18 = 72).

---
 rtl/axis_pkg.sv | 17 +
 rtl/axis_sample_packer_if.sv | 18 +
 rtl/axis_reg_slice.sv | 38 +++
 rtl/axis_sample_packer.sv | 101 ++++++++++
 tb/tb_axis_sample_packer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Shared constants and helpers for the sample-path stream stages.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

    localparam int c_partial_cnt_w = 16;

    // Lane-counter width; never narrower than one bit.
    function automatic int cnt_width(input int ratio);
        return ($clog2(ratio) < 1) ? 1 : $clog2(ratio);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_sample_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_sample_packer_if
// Description : AXI-stream beat bundle (valid/ready/data/last) with modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_sample_packer_if #(
    parameter int WIDTH = 18
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;
    logic             tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : axis_reg_slice
// Description : Single registered valid/ready stage; holds data while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_reg_slice #(
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/axis_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : axis_sample_packer
// Description : Packs RATIO narrow stream beats into one wide word, lane 0 in
//               the LSBs, with optional zero-padded early flush on tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_sample_packer
    import axis_pkg::*;
#(
    parameter int IN_WIDTH      = 18,
    parameter int RATIO         = 4,
    parameter int FLUSH_ON_LAST = 1
) (
    input  logic                       axis_clk,
    input  logic                       axis_rstn,
    axis_sample_packer_if.slave        s_axis,
    axis_sample_packer_if.master       m_axis,
    output logic [c_partial_cnt_w-1:0] partial_cnt
);
    localparam int c_out_width = IN_WIDTH * RATIO;
    localparam int c_cnt_w     = cnt_width(RATIO);
    localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(RATIO - 1);

    logic                       r_run;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [c_partial_cnt_w-1:0] r_partial_cnt;
    logic [c_out_width-1:0]     w_word;
    logic [c_out_width:0]       w_slice_out;
    logic                       w_slice_ready;
    logic                       w_acc;
    logic                       w_flush;
    logic                       w_full;
    logic                       w_close;
    logic                       w_last;

    assign s_axis.tready = r_run & w_slice_ready;
    assign w_acc         = s_axis.tvalid & s_axis.tready;
    assign w_flush       = s_axis.tlast & (FLUSH_ON_LAST != 0);
    assign w_full        = (r_cnt == c_last_lane);
    assign w_close       = w_acc & (w_full | w_flush);
    assign w_last        = w_full ? w_flush : 1'b1;
    assign partial_cnt   = r_partial_cnt;

    // Stale accumulator lanes above cnt are masked here rather than cleared.
    for (genvar l = 0; l < RATIO; l++) begin : g_lane
        if (l < RATIO - 1) begin : g_acc
            localparam logic [c_cnt_w-1:0] c_lane = c_cnt_w'(l);
            logic [IN_WIDTH-1:0] r_lane;

            always_ff @(posedge axis_clk or negedge axis_rstn) begin
                if (!axis_rstn) begin
                    r_lane <= '0;
                end else if (w_acc && !w_close && (r_cnt == c_lane)) begin
                    r_lane <= s_axis.tdata;
                end
            end

            assign w_word[l*IN_WIDTH +: IN_WIDTH] =
                (c_lane < r_cnt)  ? r_lane :
                (c_lane == r_cnt) ? s_axis.tdata : '0;
        end else begin : g_top
            assign w_word[l*IN_WIDTH +: IN_WIDTH] = w_full ? s_axis.tdata : '0;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            r_run         <= 1'b0;
            r_cnt         <= '0;
            r_partial_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_close) begin
                r_cnt <= '0;
            end else if (w_acc) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_close && !w_full && (r_partial_cnt != '1)) begin
                r_partial_cnt <= r_partial_cnt + c_partial_cnt_w'(1);
            end
        end
    end

    axis_reg_slice #(
        .WIDTH (c_out_width + 1)
    ) u_out_slice (
        .clk     (axis_clk),
        .rst_n   (axis_rstn),
        .i_valid (w_close),
        .o_ready (w_slice_ready),
        .i_data  ({w_last, w_word}),
        .o_valid (m_axis.tvalid),
        .i_ready (m_axis.tready),
        .o_data  (w_slice_out)
    );

    assign m_axis.tdata = w_slice_out[c_out_width-1:0];
    assign m_axis.tlast = w_slice_out[c_out_width];
endmodule
`default_nettype wire

// File: tb/tb_axis_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_sample_packer
// Description : Directed self-checking bench for axis_sample_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_sample_packer;
    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] pcnt;
    logic [15:0] pcnt_nf;
    int          checks = 0;
    int          errors = 0;

    axis_sample_packer_if #(.WIDTH(18)) s_if ();
    axis_sample_packer_if #(.WIDTH(72)) m_if ();
    axis_sample_packer_if #(.WIDTH(18)) nf_s ();
    axis_sample_packer_if #(.WIDTH(72)) nf_m ();

    axis_sample_packer #(.IN_WIDTH(18), .RATIO(4), .FLUSH_ON_LAST(1)) dut (
        .axis_clk    (clk),
        .axis_rstn   (rstn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .partial_cnt (pcnt)
    );

    axis_sample_packer #(.IN_WIDTH(18), .RATIO(4), .FLUSH_ON_LAST(0)) dut_nf (
        .axis_clk    (clk),
        .axis_rstn   (rstn),
        .s_axis      (nf_s),
        .m_axis      (nf_m),
        .partial_cnt (pcnt_nf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) step();
    endtask

    // Presents one beat and returns 1ns after the edge that accepted it.
    task automatic send(input logic [17:0] d, input logic l);
        int n;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        n = 0;
        while (!s_if.tready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: tready got 0 expected 1 for beat %h", d);
        end
        step();
        s_if.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
        nf_s.tvalid = 1'b0; nf_s.tdata = '0; nf_s.tlast = 1'b0; nf_m.tready = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) step();
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_if.tvalid); end
        checks++; if (m_if.tdata !== 72'd0) begin errors++; $display("FAIL rst_tdata: got %h expected 0", m_if.tdata); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", m_if.tlast); end
        checks++; if (pcnt !== 16'd0) begin errors++; $display("FAIL rst_pcnt: got %h expected 0", pcnt); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b expected 0", s_if.tready); end
        rstn = 1'b1;
        #1;
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rel_tready0: got %b expected 0", s_if.tready); end
        step();
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rel_tready1: got %b expected 1", s_if.tready); end
    endtask

    task automatic test_streaming();
        logic [71:0] exp;
        idle();
        send(18'h1, 1'b0); send(18'h2, 1'b0); send(18'h3, 1'b0); send(18'h4, 1'b0);
        exp = {18'h4, 18'h3, 18'h2, 18'h1};
        checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL str_tvalid: got %b expected 1", m_if.tvalid); end
        checks++; if (m_if.tdata !== exp) begin errors++; $display("FAIL str_tdata: got %h expected %h", m_if.tdata, exp); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL str_tlast: got %b expected 0", m_if.tlast); end
        send(18'h5, 1'b0);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL str_drain: got %b expected 0", m_if.tvalid); end
        send(18'h6, 1'b0); send(18'h7, 1'b0); send(18'h8, 1'b0);
        exp = {18'h8, 18'h7, 18'h6, 18'h5};
        checks++; if (m_if.tdata !== exp || m_if.tvalid !== 1'b1) begin errors++; $display("FAIL str_word2: got %h/%b expected %h/1", m_if.tdata, m_if.tvalid, exp); end
        checks++; if (pcnt !== 16'd0) begin errors++; $display("FAIL str_pcnt: got %h expected 0", pcnt); end
    endtask

    task automatic test_flush();
        logic [71:0] exp;
        idle();
        send(18'hA, 1'b0); send(18'hB, 1'b1);
        exp = {36'd0, 18'hB, 18'hA};
        checks++; if (m_if.tdata !== exp) begin errors++; $display("FAIL fl_tdata: got %h expected %h", m_if.tdata, exp); end
        checks++; if (m_if.tlast !== 1'b1) begin errors++; $display("FAIL fl_tlast: got %b expected 1", m_if.tlast); end
        checks++; if (pcnt !== 16'd1) begin errors++; $display("FAIL fl_pcnt: got %h expected 1", pcnt); end
        send(18'h1, 1'b0); send(18'h2, 1'b0); send(18'h3, 1'b0); send(18'h4, 1'b1);
        exp = {18'h4, 18'h3, 18'h2, 18'h1};
        checks++; if (m_if.tdata !== exp) begin errors++; $display("FAIL fl_full_tdata: got %h expected %h", m_if.tdata, exp); end
        checks++; if (m_if.tlast !== 1'b1) begin errors++; $display("FAIL fl_full_tlast: got %b expected 1", m_if.tlast); end
        checks++; if (pcnt !== 16'd1) begin errors++; $display("FAIL fl_full_pcnt: got %h expected 1", pcnt); end
        send(18'hC, 1'b1);
        exp = {54'd0, 18'hC};
        checks++; if (m_if.tdata !== exp || m_if.tlast !== 1'b1) begin errors++; $display("FAIL fl_one_lane: got %h/%b expected %h/1", m_if.tdata, m_if.tlast, exp); end
        checks++; if (pcnt !== 16'd2) begin errors++; $display("FAIL fl_one_pcnt: got %h expected 2", pcnt); end
        send(18'hD, 1'b0); send(18'hE, 1'b1);
        exp = {36'd0, 18'hE, 18'hD};
        checks++; if (m_if.tdata !== exp) begin errors++; $display("FAIL fl_mask: got %h expected %h", m_if.tdata, exp); end
        checks++; if (pcnt !== 16'd3) begin errors++; $display("FAIL fl_pcnt3: got %h expected 3", pcnt); end
    endtask

    task automatic test_backpressure();
        logic [71:0] exp;
        idle();
        m_if.tready = 1'b0;
        send(18'h1, 1'b0); send(18'h2, 1'b0); send(18'h3, 1'b0); send(18'h4, 1'b0);
        exp = {18'h4, 18'h3, 18'h2, 18'h1};
        s_if.tvalid = 1'b1; s_if.tdata = 18'h55; s_if.tlast = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL bp_tready c%0d: got %b expected 0", i, s_if.tready); end
            checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid c%0d: got %b expected 1", i, m_if.tvalid); end
            checks++; if (m_if.tdata !== exp) begin errors++; $display("FAIL bp_tdata c%0d: got %h expected %h", i, m_if.tdata, exp); end
            checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL bp_tlast c%0d: got %b expected 0", i, m_if.tlast); end
        end
        m_if.tready = 1'b1;
        #1;
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", s_if.tready); end
        step();
        s_if.tvalid = 1'b0;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", m_if.tvalid); end
        send(18'h56, 1'b0); send(18'h57, 1'b0); send(18'h58, 1'b0);
        exp = {18'h58, 18'h57, 18'h56, 18'h55};
        checks++; if (m_if.tdata !== exp || m_if.tvalid !== 1'b1) begin errors++; $display("FAIL bp_resume: got %h/%b expected %h/1", m_if.tdata, m_if.tvalid, exp); end
    endtask

    task automatic test_flush_disabled();
        logic [71:0] exp;
        nf_m.tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            nf_s.tvalid = 1'b1; nf_s.tdata = 18'(i); nf_s.tlast = (i == 2);
            checks++; if (nf_s.tready !== 1'b1) begin errors++; $display("FAIL nf_tready b%0d: got %b expected 1", i, nf_s.tready); end
            step();
            if (i < 4) begin
                checks++; if (nf_m.tvalid !== 1'b0) begin errors++; $display("FAIL nf_early b%0d: got %b expected 0", i, nf_m.tvalid); end
            end
        end
        nf_s.tvalid = 1'b0;
        exp = {18'h4, 18'h3, 18'h2, 18'h1};
        checks++; if (nf_m.tvalid !== 1'b1) begin errors++; $display("FAIL nf_tvalid: got %b expected 1", nf_m.tvalid); end
        checks++; if (nf_m.tdata !== exp) begin errors++; $display("FAIL nf_tdata: got %h expected %h", nf_m.tdata, exp); end
        checks++; if (nf_m.tlast !== 1'b0) begin errors++; $display("FAIL nf_tlast: got %b expected 0", nf_m.tlast); end
        checks++; if (pcnt_nf !== 16'd0) begin errors++; $display("FAIL nf_pcnt: got %h expected 0", pcnt_nf); end
    endtask

    task automatic test_reset_mid();
        logic [71:0] exp;
        idle();
        m_if.tready = 1'b0;
        send(18'h1, 1'b0); send(18'h2, 1'b0); send(18'h3, 1'b0); send(18'h4, 1'b0);
        checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL rm_pending: got %b expected 1", m_if.tvalid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid: got %b expected 0", m_if.tvalid); end
        checks++; if (m_if.tdata !== 72'd0) begin errors++; $display("FAIL rm_tdata: got %h expected 0", m_if.tdata); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rm_tlast: got %b expected 0", m_if.tlast); end
        checks++; if (pcnt !== 16'd0) begin errors++; $display("FAIL rm_pcnt: got %h expected 0", pcnt); end
        step();
        rstn = 1'b1;
        #1;
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rm_tready0: got %b expected 0", s_if.tready); end
        step();
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rm_tready1: got %b expected 1", s_if.tready); end
        m_if.tready = 1'b1;
        send(18'h11, 1'b0); send(18'h12, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rm_mid_tready: got %b expected 0", s_if.tready); end
        step();
        rstn = 1'b1;
        step();
        send(18'h21, 1'b0); send(18'h22, 1'b0); send(18'h23, 1'b0); send(18'h24, 1'b0);
        exp = {18'h24, 18'h23, 18'h22, 18'h21};
        checks++; if (m_if.tdata !== exp || m_if.tlast !== 1'b0) begin errors++; $display("FAIL rm_lane0: got %h/%b expected %h/0", m_if.tdata, m_if.tlast, exp); end
        checks++; if (pcnt !== 16'd0) begin errors++; $display("FAIL rm_pcnt_after: got %h expected 0", pcnt); end
    endtask

    task automatic test_saturation();
        idle();
        checks++; if (pcnt !== 16'd0) begin errors++; $display("FAIL sat_start: got %h expected 0", pcnt); end
        s_if.tvalid = 1'b1; s_if.tdata = 18'h3; s_if.tlast = 1'b1;
        repeat (65534) step();
        checks++; if (pcnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", pcnt); end
        checks++; if (m_if.tdata !== {54'd0, 18'h3} || m_if.tlast !== 1'b1) begin errors++; $display("FAIL sat_word: got %h/%b expected 3/1", m_if.tdata, m_if.tlast); end
        repeat (6) step();
        s_if.tvalid = 1'b0;
        checks++; if (pcnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", pcnt); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_flush();
        test_backpressure();
        test_flush_disabled();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
